// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_if
//  Purpose  : EX-stage M-extension bus: operands, forwarding, result/status.
//  Revision : 1.0  initial release
// ============================================================================
interface ex_muldiv_if #(
    parameter int size = 32
);
    logic            valid_i;
    logic [2:0]      op_i;
    logic [size-1:0] A_i;
    logic [size-1:0] B_i;
    logic [size-1:0] Data_MEM;
    logic [size-1:0] Data_WB;
    logic [1:0]      A_sel;
    logic [1:0]      B_sel;
    logic            flush_i;
    logic [size-1:0] result_o;
    logic            done_o;
    logic            busy_o;
    logic            stall_o;

    // Unit side
    modport slave (
        input  valid_i, op_i, A_i, B_i, Data_MEM, Data_WB, A_sel, B_sel, flush_i,
        output result_o, done_o, busy_o, stall_o
    );

    // Pipeline side
    modport master (
        output valid_i, op_i, A_i, B_i, Data_MEM, Data_WB, A_sel, B_sel, flush_i,
        input  result_o, done_o, busy_o, stall_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv
//  Purpose  : Iterative radix-2 multiply / restoring divide unit for the EX
//             stage. Works on operand magnitudes and fixes the sign when the
//             final result is captured.
//  Revision : 1.0  initial release
// ============================================================================
module ex_muldiv #(
    parameter int size  = 32,
    parameter int cnt_w = $clog2(size) + 1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    ex_muldiv_if.slave    bus
);

    localparam logic [2:0] c_MULH   = 3'd1;
    localparam logic [2:0] c_MULHSU = 3'd2;
    localparam logic [2:0] c_DIV    = 3'd4;
    localparam logic [2:0] c_REM    = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [cnt_w-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [2*size-1:0] acc_q;
    logic [2*size-1:0] acc_d;
    logic [size-1:0]   dvsr_q;
    logic [size-1:0]   result_q;
    logic [size-1:0]   result_d;
    logic              done_q;
    logic              busy_q;

    logic [size-1:0]   w_opa, w_opb, w_mag_a, w_mag_b, w_spec;
    logic              w_sgn_a, w_sgn_b, w_div0, w_ovf, w_neg, w_special;
    logic [size:0]     w_sum;
    logic [size-1:0]   w_addend;
    logic [size:0]     w_shifted;
    logic [size-1:0]   w_diff;
    logic              w_ge;
    logic [2*size-1:0] w_prod;
    logic [size-1:0]   w_quo;
    logic [size-1:0]   w_quo_s;

    // Forwarding muxes; select 11 aliases the MEM-stage value
    always_comb begin
        case (bus.A_sel)
            2'b00:   w_opa = bus.A_i;
            2'b10:   w_opa = bus.Data_WB;
            default: w_opa = bus.Data_MEM;
        endcase
        case (bus.B_sel)
            2'b00:   w_opb = bus.B_i;
            2'b10:   w_opb = bus.Data_WB;
            default: w_opb = bus.Data_MEM;
        endcase
    end

    // Accept-time decode: operand signs, magnitudes, and the divide corner cases
    always_comb begin
        w_sgn_a = ((bus.op_i == c_MULH) || (bus.op_i == c_MULHSU) ||
                   (bus.op_i == c_DIV)  || (bus.op_i == c_REM)) && w_opa[size-1];
        w_sgn_b = ((bus.op_i == c_MULH) || (bus.op_i == c_DIV) ||
                   (bus.op_i == c_REM)) && w_opb[size-1];
        w_mag_a = w_sgn_a ? (~w_opa + 1'b1) : w_opa;
        w_mag_b = w_sgn_b ? (~w_opb + 1'b1) : w_opb;
        w_div0  = bus.op_i[2] && (w_opb == {size{1'b0}});
        w_ovf   = ((bus.op_i == c_DIV) || (bus.op_i == c_REM)) &&
                  (w_opa == {1'b1, {(size-1){1'b0}}}) && (w_opb == {size{1'b1}});
        // Remainder follows the dividend's sign; products and quotients use sA^sB
        w_neg   = (bus.op_i[2] && bus.op_i[1]) ? w_sgn_a : (w_sgn_a ^ w_sgn_b);
        w_special = w_div0 || w_ovf;
        if (w_div0) begin
            w_spec = bus.op_i[1] ? w_opa : {size{1'b1}};
        end else begin
            w_spec = bus.op_i[1] ? {size{1'b0}} : w_opa;
        end
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide,
    // plus the signed/selected result that is captured on the final step
    always_comb begin
        w_addend  = acc_q[0] ? dvsr_q : {size{1'b0}};
        w_sum     = {1'b0, acc_q[2*size-1:size]} + {1'b0, w_addend};
        w_shifted = {acc_q[2*size-1:size], acc_q[size-1]};
        w_diff    = w_shifted[size-1:0] - dvsr_q;
        w_ge      = (w_shifted >= {1'b0, dvsr_q});
        if (op_q[2]) begin
            acc_d = {(w_ge ? w_diff : w_shifted[size-1:0]), acc_q[size-2:0], w_ge};
        end else begin
            acc_d = {w_sum, acc_q[size-1:1]};
        end
        w_prod  = neg_q ? (~acc_d + 1'b1) : acc_d;
        w_quo   = op_q[1] ? acc_d[2*size-1:size] : acc_d[size-1:0];
        w_quo_s = neg_q ? (~w_quo + 1'b1) : w_quo;
        if (op_q[2]) begin
            result_d = w_quo_s;
        end else if (op_q[1:0] == 2'b00) begin
            result_d = w_prod[size-1:0];
        end else begin
            result_d = w_prod[2*size-1:size];
        end
    end

    // Control FSM with registered done/busy; flush overrides everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush_i) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.valid_i) begin
                            op_q   <= bus.op_i;
                            neg_q  <= w_neg;
                            dvsr_q <= w_mag_b;
                            acc_q  <= {{size{1'b0}}, w_mag_a};
                            if (w_special) begin
                                state_q  <= DONE;
                                result_q <= w_spec;
                                done_q   <= 1'b1;
                                cnt_q    <= '0;
                            end else begin
                                state_q <= BUSY;
                                busy_q  <= 1'b1;
                                cnt_q   <= cnt_w'(size);
                            end
                        end
                    end
                    BUSY: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - cnt_w'(1);
                        if (cnt_q == cnt_w'(1)) begin
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            result_q <= result_d;
                            done_q   <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.result_o = result_q;
    assign bus.done_o   = done_q;
    assign bus.busy_o   = busy_q;
    assign bus.stall_o  = bus.valid_i & ~bus.flush_i & (state_q != DONE);

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_muldiv
//  Purpose  : Self-checking bench: arithmetic reference model with a per-cycle
//             compare of every output, plus directed literal vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_muldiv;

    localparam int SZ = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    ex_muldiv_if #(.size(SZ)) bus ();

    ex_muldiv #(.size(SZ)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        longint      sp;
        int          sa, sb, q;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin sp = longint'(sa) * longint'(sb); p = sp; return p[63:32]; end
            3'd2: begin sp = longint'(sa) * longint'({32'd0, b}); p = sp; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                q = sa / sb;
                return q;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                q = sa % sb;
                return q;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && ((b == 0) ||
            (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))))
            return 1;
        return SZ + 1;
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r,
                                        input logic [31:0] mem, input logic [31:0] wb);
        if (sel == 2'b00) return r;
        if (sel == 2'b10) return wb;
        return mem;
    endfunction

    logic [31:0] ex_a, ex_b, ex_res;
    int          ex_lat;
    assign ex_a   = fwd(bus.A_sel, bus.A_i, bus.Data_MEM, bus.Data_WB);
    assign ex_b   = fwd(bus.B_sel, bus.B_i, bus.Data_MEM, bus.Data_WB);
    assign ex_res = ref_result(bus.op_i, ex_a, ex_b);
    assign ex_lat = ref_lat(bus.op_i, ex_a, ex_b);

    // Model state: cycles left until the result appears, pending and last result
    logic        m_done;
    int          m_left;
    logic [31:0] m_pend, m_last;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_done <= 1'b0;
            m_left <= 0;
            m_pend <= '0;
            m_last <= '0;
        end else if (bus.flush_i) begin
            m_done <= 1'b0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_last <= m_pend;
        end else if (!m_done && bus.valid_i) begin
            m_pend <= ex_res;
            m_left <= ex_lat - 1;
            m_done <= (ex_lat == 1);
            if (ex_lat == 1) m_last <= ex_res;
        end else begin
            m_done <= 1'b0;
        end
    end

    // Per-cycle compare of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("done_o",   {31'd0, bus.done_o},  {31'd0, m_done});
            chk("busy_o",   {31'd0, bus.busy_o},  {31'd0, (m_left > 0)});
            chk("stall_o",  {31'd0, bus.stall_o}, {31'd0, bus.valid_i & ~bus.flush_i & ~m_done});
            chk("result_o", bus.result_o, m_last);
        end
    end

    // ---------------- directed stimulus ----------------
    // Called at posedge+1 of the accept cycle; returns at posedge+1 of the done cycle
    task automatic run(input string nm, input logic [2:0] op, input logic [31:0] ai,
                       input logic [31:0] bi, input logic [31:0] mem, input logic [31:0] wb,
                       input logic [1:0] as, input logic [1:0] bs,
                       input logic [31:0] exp, input int lat);
        int got;
        got = -1;
        bus.valid_i = 1'b1; bus.op_i = op;
        bus.A_i = ai; bus.B_i = bi; bus.Data_MEM = mem; bus.Data_WB = wb;
        bus.A_sel = as; bus.B_sel = bs;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.done_o) begin
                got = c;
                break;
            end
            // Operands and op are latched at accept; later changes must not matter
            bus.A_i = ~ai; bus.B_i = ~bi; bus.Data_MEM = ~mem; bus.Data_WB = ~wb;
            bus.op_i = op ^ 3'b100; bus.A_sel = ~as;
        end
        bus.valid_i = 1'b0;
        chk({nm, " latency"}, got, lat);
        chk({nm, " result"}, bus.result_o, exp);
    endtask

    task automatic expect_no_done(input string nm);
        int pulses;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done_o) pulses++;
        end
        chk({nm, " no done"}, pulses, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        bus.valid_i = 0; bus.op_i = 0; bus.A_i = 0; bus.B_i = 0;
        bus.Data_MEM = 0; bus.Data_WB = 0; bus.A_sel = 0; bus.B_sel = 0; bus.flush_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset result_o", bus.result_o, 32'd0);
        chk("reset done_o", {31'd0, bus.done_o}, 32'd0);
        chk("reset busy_o", {31'd0, bus.busy_o}, 32'd0);
        chk_en = 1'b1;

        // Accept in the very first cycle after release
        rst_n = 1'b1;
        run("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0, 2'b00, 2'b00, 32'hFFFF_FFEB, 33);
        next_cycle(); run("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 32'hFFFF_FFFE, 33);
        next_cycle(); run("MULH -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 32'h0, 33);
        next_cycle(); run("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 32'h8000_0000, 1);
        next_cycle(); run("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 32'h0, 1);
        next_cycle(); run("DIVU /0", 3'd5, 32'h1234, 32'h0, 0, 0, 2'b00, 2'b00, 32'hFFFF_FFFF, 1);
        next_cycle(); run("REMU /0", 3'd7, 32'h1234, 32'h0, 0, 0, 2'b00, 2'b00, 32'h1234, 1);
        next_cycle(); run("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, 2'b00, 2'b00, 32'hFFFF_FFFD, 33);
        next_cycle(); run("REM -7%2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0, 2'b00, 2'b00, 32'hFFFF_FFFF, 33);
        next_cycle(); run("DIV fwd WB", 3'd4, 32'hDEAD, 32'd2, 32'h55, 32'hFFFF_FFF9, 2'b10, 2'b00, 32'hFFFF_FFFD, 33);
        next_cycle(); run("REM fwd WB", 3'd6, 32'hDEAD, 32'd2, 32'h55, 32'hFFFF_FFF9, 2'b10, 2'b00, 32'hFFFF_FFFF, 33);
        next_cycle(); run("MULHSU -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 0, 0, 2'b00, 2'b00, 32'hFFFF_FFFF, 33);
        next_cycle(); run("DIVU fwd MEM", 3'd5, 32'd100, 32'hBEEF, 32'd7, 32'd9, 2'b00, 2'b01, 32'd14, 33);
        next_cycle(); run("REMU sel11", 3'd7, 32'd100, 32'hBEEF, 32'd7, 32'd9, 2'b00, 2'b11, 32'd2, 33);
        next_cycle(); run("MUL low", 3'd0, 32'h1234_5678, 32'h10, 0, 0, 2'b00, 2'b00, 32'h2345_6780, 33);
        next_cycle(); run("DIV 7/-2", 3'd4, 32'd7, 32'hFFFF_FFFE, 0, 0, 2'b00, 2'b00, 32'hFFFF_FFFD, 33);
        next_cycle(); run("REM 7%-2", 3'd6, 32'd7, 32'hFFFF_FFFE, 0, 0, 2'b00, 2'b00, 32'd1, 33);
        next_cycle(); run("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, 2'b00, 2'b00, 32'h4000_0000, 33);
        next_cycle(); run("REM min/0", 3'd6, 32'h8000_0000, 32'h0, 0, 0, 2'b00, 2'b00, 32'h8000_0000, 1);
        next_cycle(); run("DIV signed /0", 3'd4, 32'hFFFF_FFF9, 32'h0, 0, 0, 2'b00, 2'b00, 32'hFFFF_FFFF, 1);

        // Flush in cycle 10 of a DIVU
        next_cycle();
        bus.valid_i = 1; bus.op_i = 3'd5; bus.A_i = 32'd1000; bus.B_i = 32'd3;
        bus.A_sel = 2'b00; bus.B_sel = 2'b00;
        repeat (10) next_cycle();
        bus.flush_i = 1; bus.valid_i = 0;
        next_cycle();
        bus.flush_i = 0;
        chk("flush busy cleared", {31'd0, bus.busy_o}, 32'd0);
        chk("flush keeps result", bus.result_o, 32'hFFFF_FFFF);
        expect_no_done("flush");

        // Flush wins over a simultaneous accept
        bus.valid_i = 1; bus.flush_i = 1; bus.op_i = 3'd0; bus.A_i = 32'd3; bus.B_i = 32'd4;
        next_cycle();
        bus.valid_i = 0; bus.flush_i = 0;
        chk("flush vs accept busy", {31'd0, bus.busy_o}, 32'd0);
        expect_no_done("flush vs accept");

        // Reset in cycle 5 of a MUL
        bus.valid_i = 1; bus.op_i = 3'd0; bus.A_i = 32'd9; bus.B_i = 32'd11;
        repeat (5) next_cycle();
        rst_n = 0; bus.valid_i = 0;
        #1;
        chk("async reset result_o", bus.result_o, 32'd0);
        chk("async reset busy_o", {31'd0, bus.busy_o}, 32'd0);
        chk("async reset done_o", {31'd0, bus.done_o}, 32'd0);
        next_cycle();
        rst_n = 1;
        expect_no_done("after reset");

        run("MUL post reset", 3'd0, 32'd9, 32'd11, 0, 0, 2'b00, 2'b00, 32'd99, 33);
        next_cycle(); next_cycle();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
